// File: rtl/text_pkg.sv
// Shared definitions for the text row sequencer: RGB stream field layout,
// sequencer states and elaboration-time sizing helpers.
package text_pkg;

   localparam int STREAM_W = 26;
   localparam int ACTIVE   = 0;
   localparam int VS       = 1;
   localparam int HS       = 2;
   localparam int YC_LSB   = 3;
   localparam int XC_LSB   = 13;
   localparam int RGB_LSB  = 23;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } state_e;

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

   // Exact log2 for power-of-2 arguments; pair with is_pow2 at elaboration.
   function automatic int clog2_pow2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) == v) r = i;
      end
      return r;
   endfunction

endpackage

// File: rtl/text_line_buffer.sv
// Double-buffered text line: writes go to the shadow copy, a swap strobe
// copies every shadow entry into the displayed copy in a single edge.
module text_line_buffer
   import text_pkg::*;
#(
   parameter int          NCOLS = 16,
   parameter logic [7:0]  BLANK = 8'h20
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [$clog2(NCOLS)-1:0] wr_addr,
   input  logic [7:0]               wr_data,
   input  logic                     swap,
   input  logic [$clog2(NCOLS)-1:0] rd_addr,
   output logic [7:0]               rd_data
);

   logic [7:0] shadow_q [NCOLS];
   logic [7:0] disp_q   [NCOLS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCOLS; i++) begin
            shadow_q[i] <= BLANK;
            disp_q[i]   <= BLANK;
         end
      end else begin
         if (wr_en) shadow_q[wr_addr] <= wr_data;
         if (swap) begin
            for (int i = 0; i < NCOLS; i++) disp_q[i] <= shadow_q[i];
         end
      end
   end

   assign rd_data = disp_q[rd_addr];

endmodule

// File: rtl/text_row_sequencer.sv
// Feeds one glyph renderer with per-cell character code and cell origin so it
// draws a full row of NCOLS characters; the text line swaps only at frame start.
module text_row_sequencer
   import text_pkg::*;
#(
   parameter int          NCOLS  = 16,
   parameter int          GSIZE  = 16,
   parameter int          BASE_X = 0,
   parameter int          BASE_Y = 0,
   parameter logic [7:0]  BLANK  = 8'h20
) (
   input  logic                     px_clk,
   input  logic                     rstn,
   input  logic [STREAM_W-1:0]      RGBStr_i,
   input  logic                     wr_en,
   input  logic [$clog2(NCOLS)-1:0] wr_addr,
   input  logic [7:0]               wr_char,
   output logic                     wr_ready,
   input  logic                     commit,
   output logic                     busy,
   output logic [7:0]               character,
   output logic [9:0]               pos_x,
   output logic [9:0]               pos_y
);

   localparam int         AW = clog2_pow2(NCOLS);
   localparam int         LG = clog2_pow2(GSIZE);
   localparam logic [9:0] BX = BASE_X[9:0];
   localparam logic [9:0] BY = BASE_Y[9:0];

   if (!is_pow2(NCOLS) || NCOLS < 2 || NCOLS > 64) begin : g_bad_ncols
      $error("NCOLS must be a power of 2 in 2..64");
   end
   if (!is_pow2(GSIZE) || GSIZE < 8) begin : g_bad_gsize
      $error("GSIZE must be a power of 2, at least 8");
   end
   if (BASE_X + NCOLS * GSIZE > 1024) begin : g_bad_place
      $error("row does not fit: BASE_X + NCOLS*GSIZE exceeds 1024");
   end

   state_e     state_q, state_d;
   logic       rdy_q;
   logic       vs_prev_q;
   logic [7:0] char_q;
   logic [9:0] posx_q;

   logic          accept, vs_rise, swap, wr_ok;
   logic [9:0]    xc;
   logic [10:0]   dx, dq;
   logic [AW-1:0] col;
   logic [7:0]    rd_char;
   logic          unused_stream;

   assign xc            = RGBStr_i[XC_LSB +: 10];
   assign unused_stream = ^{RGBStr_i[RGB_LSB +: 3], RGBStr_i[YC_LSB +: 10],
                            RGBStr_i[HS], RGBStr_i[ACTIVE]};

   // rdy_q keeps the write port closed until the first edge after reset release
   assign accept  = rdy_q && (state_q == IDLE);
   assign wr_ok   = accept && wr_en;
   assign vs_rise = RGBStr_i[VS] && !vs_prev_q;
   assign swap    = (state_q == PENDING) && vs_rise;

   always_comb begin
      state_d = state_q;
      if (accept && commit) state_d = PENDING;
      else if (swap)        state_d = IDLE;
   end

   // Left of the row clamps to column 0, right of it to the last column
   always_comb begin
      dx  = {1'b0, xc} - {1'b0, BX};
      dq  = dx >> LG;
      col = '0;
      if (!dx[10]) begin
         if (dq > 11'(NCOLS - 1)) col = AW'(NCOLS - 1);
         else                     col = dq[AW-1:0];
      end
   end

   text_line_buffer #(
      .NCOLS (NCOLS),
      .BLANK (BLANK)
   ) u_buf (
      .clk     (px_clk),
      .rst_n   (rstn),
      .wr_en   (wr_ok),
      .wr_addr (wr_addr),
      .wr_data (wr_char),
      .swap    (swap),
      .rd_addr (col),
      .rd_data (rd_char)
   );

   always_ff @(posedge px_clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         rdy_q     <= 1'b0;
         vs_prev_q <= 1'b0;
         char_q    <= BLANK;
         posx_q    <= BX;
      end else begin
         state_q   <= state_d;
         rdy_q     <= 1'b1;
         vs_prev_q <= RGBStr_i[VS];
         char_q    <= rd_char;
         posx_q    <= BX + (10'(col) << LG);
      end
   end

   assign wr_ready  = accept;
   assign busy      = (state_q == PENDING);
   assign character = char_q;
   assign pos_x     = posx_q;
   assign pos_y     = BY;

endmodule

// File: tb/tb_text_row_sequencer.sv
// Directed bench for text_row_sequencer: reset, column scan table, commit,
// lockout, commit/VS collision and reset during a pending swap.
module tb_text_row_sequencer;

   localparam int NC = 16;
   localparam int GS = 16;
   localparam int BX = 100;
   localparam int BY = 40;

   logic        clk;
   logic        rstn;
   logic [25:0] strm;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [7:0]  wr_char;
   logic        wr_ready;
   logic        commit;
   logic        busy;
   logic [7:0]  character;
   logic [9:0]  pos_x;
   logic [9:0]  pos_y;

   int n_cmp;
   int n_err;

   text_row_sequencer #(
      .NCOLS  (NC),
      .GSIZE  (GS),
      .BASE_X (BX),
      .BASE_Y (BY),
      .BLANK  (8'h20)
   ) dut (
      .px_clk    (clk),
      .rstn      (rstn),
      .RGBStr_i  (strm),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_char   (wr_char),
      .wr_ready  (wr_ready),
      .commit    (commit),
      .busy      (busy),
      .character (character),
      .pos_x     (pos_x),
      .pos_y     (pos_y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] xc;
      logic [9:0] pos;
      logic [7:0] ch;
   } vec_t;

   vec_t vt [12];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setpx(input logic [9:0] xc, input logic vs);
      strm = {3'b111, xc, 10'd5, 1'b0, vs, 1'b1};
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_char = d;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      int bad;
      n_cmp   = 0;
      n_err   = 0;
      rstn    = 1'b0;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_char = '0;
      commit  = 1'b0;
      setpx(10'd0, 1'b0);

      // disp after the first swap: col0=30, col2=41, col15=7E, rest 20
      vt[0]  = '{10'd132,  10'd132, 8'h41};
      vt[1]  = '{10'd147,  10'd132, 8'h41};
      vt[2]  = '{10'd148,  10'd148, 8'h20};
      vt[3]  = '{10'd50,   10'd100, 8'h30};
      vt[4]  = '{10'd1000, 10'd340, 8'h7E};
      vt[5]  = '{10'd100,  10'd100, 8'h30};
      vt[6]  = '{10'd99,   10'd100, 8'h30};
      vt[7]  = '{10'd115,  10'd100, 8'h30};
      vt[8]  = '{10'd116,  10'd116, 8'h20};
      vt[9]  = '{10'd355,  10'd340, 8'h7E};
      vt[10] = '{10'd356,  10'd340, 8'h7E};
      vt[11] = '{10'd0,    10'd100, 8'h30};

      repeat (3) tick();
      chk("rst_char", character, 8'h20);
      chk("rst_posx", pos_x, 10'd100);
      chk("rst_posy", pos_y, 10'd40);
      chk("rst_busy", busy, 1'b0);
      chk("rst_wr_ready", wr_ready, 1'b0);
      rstn = 1'b1;
      tick();
      chk("rel_wr_ready", wr_ready, 1'b1);

      wr(4'd2, 8'h41);
      wr(4'd15, 8'h7E);
      wr(4'd0, 8'h30);
      commit = 1'b1;
      tick();
      commit = 1'b0;
      chk("load_busy", busy, 1'b1);
      setpx(10'd0, 1'b1);
      tick();
      chk("load_swap_busy", busy, 1'b0);
      setpx(10'd0, 1'b0);
      tick();

      for (int i = 0; i < 12; i++) begin
         setpx(vt[i].xc, 1'b0);
         tick();
         chk($sformatf("scan%0d_posx", i), pos_x, vt[i].pos);
         chk($sformatf("scan%0d_char", i), character, vt[i].ch);
      end

      // write and commit together; then a locked-out write to col 4
      wr_en = 1'b1; wr_addr = 4'd3; wr_char = 8'h5A; commit = 1'b1;
      tick();
      wr_en = 1'b0; commit = 1'b0;
      chk("cmt_busy", busy, 1'b1);
      chk("cmt_wr_ready", wr_ready, 1'b0);
      setpx(10'd148, 1'b0);
      wr(4'd4, 8'h99);
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (character !== 8'h20 || busy !== 1'b1) bad++;
      end
      chk("hold_no_swap", bad, 0);
      setpx(10'd148, 1'b1);
      tick();
      chk("vs_busy", busy, 1'b0);
      chk("vs_char_same_edge", character, 8'h20);
      tick();
      chk("vs_char_new", character, 8'h5A);

      setpx(10'd148, 1'b0);
      commit = 1'b1;
      tick();
      commit = 1'b0;
      setpx(10'd164, 1'b1);
      tick();
      tick();
      chk("lockout_posx", pos_x, 10'd164);
      chk("lockout_char", character, 8'h20);

      // commit accepted on the same cycle as a VS rise
      setpx(10'd164, 1'b0);
      tick();
      wr(4'd5, 8'h66);
      commit = 1'b1;
      setpx(10'd180, 1'b1);
      tick();
      commit = 1'b0;
      chk("coll_busy", busy, 1'b1);
      tick();
      tick();
      chk("coll_char_old", character, 8'h20);
      setpx(10'd180, 1'b0);
      tick();
      chk("coll_busy2", busy, 1'b1);
      setpx(10'd180, 1'b1);
      tick();
      chk("coll_busy3", busy, 1'b0);
      tick();
      chk("coll_char_new", character, 8'h66);

      // reset while a swap is pending
      setpx(10'd196, 1'b0);
      tick();
      wr(4'd6, 8'h11);
      commit = 1'b1;
      tick();
      commit = 1'b0;
      chk("mid_busy", busy, 1'b1);
      rstn = 1'b0;
      #2;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_wr_ready", wr_ready, 1'b0);
      chk("mid_rst_char", character, 8'h20);
      tick();
      rstn = 1'b1;
      tick();
      setpx(10'd196, 1'b1);
      tick();
      tick();
      chk("post_busy", busy, 1'b0);
      chk("post_col6", character, 8'h20);
      setpx(10'd132, 1'b0);
      tick();
      chk("post_col2", character, 8'h20);
      setpx(10'd100, 1'b0);
      tick();
      chk("post_col0", character, 8'h20);
      setpx(10'd1000, 1'b0);
      tick();
      chk("post_col15", character, 8'h20);
      chk("post_col15_posx", pos_x, 10'd340);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
